// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : MEM-stage data-port responder with programmable wait states.
//             Optional macro DMEM_POSTED_WRITE_EN adds a one-entry posted
//             write buffer drained through a DRAIN state.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        mem_stall,
   output logic        mem_err
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_BUSY  = 2'd1;
   localparam logic [1:0] c_DONE  = 2'd2;
   localparam logic [1:0] c_DRAIN = 2'd3;
   localparam logic [3:0] c_WAIT  = WAIT_CYCLES[3:0];

   logic [31:0]           r_mem [0:(2**ADDR_WIDTH)-1];
   logic [1:0]            r_state;
   logic [3:0]            r_cnt;
   logic                  r_op_wr;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic                  r_oor;
   logic [31:0]           r_wdata;
   logic [31:0]           r_din;
   logic                  r_err;

   logic                  w_req;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_oor;
   logic                  w_bad;
   logic                  w_post;
   logic                  w_access;
   logic                  w_ram_we;

   assign w_req = mem_ren | mem_wen;
   assign w_idx = mem_addr[ADDR_WIDTH+1:2];

   generate
      if (ADDR_WIDTH < 30) begin : g_range_chk
         assign w_oor = |mem_addr[31:ADDR_WIDTH+2];
      end else begin : g_full_range
         assign w_oor = 1'b0;
      end
   endgenerate

   assign w_bad = w_oor | (|mem_addr[1:0]) | (mem_ren & mem_wen);

`ifdef DMEM_POSTED_WRITE_EN
   // The buffer is only ever occupied in DRAIN, so it is empty whenever IDLE.
   assign w_post = (r_state == c_IDLE) & mem_wen;
`else
   assign w_post = 1'b0;
`endif

   assign mem_stall = rst_n & w_req & (r_state != c_DONE) & ~w_post;

   // The RAM is touched only once the wait count has run out.
   assign w_access = ((r_state == c_BUSY) || (r_state == c_DRAIN)) && (r_cnt == 4'd0);
   assign w_ram_we = rst_n & w_access & r_op_wr & ~r_oor;

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
         r_cnt   <= 4'd0;
         r_op_wr <= 1'b0;
         r_idx   <= '0;
         r_oor   <= 1'b0;
         r_wdata <= 32'd0;
         r_din   <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_req) begin
                  r_op_wr <= mem_wen;
                  r_idx   <= w_idx;
                  r_oor   <= w_oor;
                  r_wdata <= mem_dout;
                  r_cnt   <= c_WAIT;
                  if (w_bad) begin
                     r_err <= 1'b1;
                  end
                  r_state <= w_post ? c_DRAIN : c_BUSY;
               end
            end
            c_BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  if (!r_op_wr) begin
                     r_din <= r_oor ? 32'd0 : r_mem[r_idx];
                  end
                  r_state <= c_DONE;
               end
            end
            c_DONE: begin
               r_state <= c_IDLE;
            end
`ifdef DMEM_POSTED_WRITE_EN
            c_DRAIN: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= c_IDLE;
               end
            end
`endif
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign mem_din = r_din;
   assign mem_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Directed self-checking bench for data_mem_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

   localparam int ADDR_WIDTH  = 10;
   localparam int WAIT_CYCLES = 2;
`ifdef DMEM_POSTED_WRITE_EN
   localparam int WR_STALL = 0;
`else
   localparam int WR_STALL = WAIT_CYCLES + 2;
`endif
   localparam int RD_STALL = WAIT_CYCLES + 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        mem_stall;
   logic        mem_err;

   int n_vec = 0;
   int n_err = 0;

   data_mem_responder #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_ren  (mem_ren),
      .mem_wen  (mem_wen),
      .mem_addr (mem_addr),
      .mem_dout (mem_dout),
      .mem_din  (mem_din),
      .mem_stall(mem_stall),
      .mem_err  (mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one request just after an edge, counts stalled cycles up to
   // the acknowledge, and optionally checks the stall length and read data.
   task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input int exp_stall,
                         input logic chk_din, input logic [31:0] exp_din);
      int  stalls;
      bit  acked;
      stalls   = 0;
      acked    = 1'b0;
      mem_ren  = ~wr;
      mem_wen  = wr;
      mem_addr = addr;
      mem_dout = data;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mem_stall) begin
            stalls++;
         end else begin
            acked = 1'b1;
            break;
         end
      end
      if (!acked) begin
         chk({tag, "_timeout"}, 32'(acked), 32'd1);
      end
      if (exp_stall >= 0) begin
         chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
      end
      if (chk_din) begin
         chk({tag, "_din"}, mem_din, exp_din);
      end
      @(posedge clk);
      #1;
      mem_ren = 1'b0;
      mem_wen = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      idle(n);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      mem_ren  = 1'b1;
      mem_wen  = 1'b0;
      mem_addr = 32'h0;
      mem_dout = 32'h0;

      // Reset held with a read request pending
      idle(2);
      @(negedge clk);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_din", mem_din, 32'd0);
      chk("rst_err", 32'(mem_err), 32'd0);
      @(posedge clk);
      #1;
      mem_ren = 1'b0;
      rst_n   = 1'b1;
      idle(1);

      // Known background contents
      access("wr_w0", 1'b1, 32'h0000_0000, 32'h1111_1111, WR_STALL, 1'b0, 32'h0);
      idle(4);
      access("wr_w20", 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, WR_STALL, 1'b0, 32'h0);
      idle(4);

      // Write then read back with wait states
      access("wr_10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, WR_STALL, 1'b0, 32'h0);
      idle(4);
      access("rd_10", 1'b0, 32'h0000_0010, 32'h0, RD_STALL, 1'b1, 32'hDEAD_BEEF);
      chk("err_clean", 32'(mem_err), 32'd0);
      idle(3);
      chk("din_held", mem_din, 32'hDEAD_BEEF);

      // A write must not disturb the last read data
      access("wr_0c", 1'b1, 32'h0000_000C, 32'h0BAD_F00D, WR_STALL, 1'b1, 32'hDEAD_BEEF);
      idle(4);

      // Misaligned read ignores the low address bits
      access("rd_13", 1'b0, 32'h0000_0013, 32'h0, RD_STALL, 1'b1, 32'hDEAD_BEEF);
      chk("err_misal", 32'(mem_err), 32'd1);

      // Reset clears flags but keeps RAM
      do_reset(2);
      chk("rst2_err", 32'(mem_err), 32'd0);
      chk("rst2_din", mem_din, 32'd0);
      access("rd_10_kept", 1'b0, 32'h0000_0010, 32'h0, RD_STALL, 1'b1, 32'hDEAD_BEEF);

      // Out-of-range write suppressed, out-of-range read returns zero
      access("wr_oor", 1'b1, 32'h0001_0000, 32'h1234_5678, WR_STALL, 1'b0, 32'h0);
      idle(4);
      chk("err_oor", 32'(mem_err), 32'd1);
      access("rd_w0", 1'b0, 32'h0000_0000, 32'h0, RD_STALL, 1'b1, 32'h1111_1111);
      access("rd_oor", 1'b0, 32'h0001_0000, 32'h0, RD_STALL, 1'b1, 32'h0000_0000);

      // Both enables: treated as a write and flagged
      do_reset(1);
      mem_ren  = 1'b1;
      mem_wen  = 1'b1;
      mem_addr = 32'h0000_0030;
      mem_dout = 32'h7777_0000;
      @(posedge clk);
      #1;
      mem_ren = 1'b0;
      mem_wen = 1'b0;
      chk("err_both", 32'(mem_err), 32'd1);
      idle(6);
      access("rd_30", 1'b0, 32'h0000_0030, 32'h0, RD_STALL, 1'b1, 32'h7777_0000);

      // Reset in cycle 2 of a write abandons it
      do_reset(1);
      mem_wen  = 1'b1;
      mem_addr = 32'h0000_0020;
      mem_dout = 32'hCAFE_F00D;
      idle(2);
      rst_n = 1'b0;
      idle(2);
      mem_wen = 1'b0;
      rst_n   = 1'b1;
      idle(1);
      access("rd_20", 1'b0, 32'h0000_0020, 32'h0, RD_STALL, 1'b1, 32'hA5A5_A5A5);

      // Write immediately followed by a read of the same word
      idle(2);
`ifdef DMEM_POSTED_WRITE_EN
      access("pw_40", 1'b1, 32'h0000_0040, 32'h55AA_55AA, 0, 1'b0, 32'h0);
      access("pr_40", 1'b0, 32'h0000_0040, 32'h0, 7, 1'b1, 32'h55AA_55AA);
`else
      access("bw_40", 1'b1, 32'h0000_0040, 32'h55AA_55AA, WAIT_CYCLES + 2, 1'b0, 32'h0);
      access("br_40", 1'b0, 32'h0000_0040, 32'h0, WAIT_CYCLES + 2, 1'b1, 32'h55AA_55AA);
`endif
      chk("err_final", 32'(mem_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
